register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG0, default 0; when 1, register 0 reads as 0 and ignores writes and reservations.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-005 SHALL have ports clk  in  1  rising-edge clock for all state.
REQ-006 SHALL have ports rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  in  ADDR_W  read port addresses.
REQ-008 SHALL have ports rd_data_a, rd_data_b  out  DATA_W  combinational read data.
REQ-009 SHALL have ports wr_en_a, wr_en_b  in  1  write enables, ports A and B.
REQ-010 SHALL have ports wr_addr_a, wr_addr_b  in  ADDR_W  write addresses.
REQ-011 SHALL have ports wr_data_a, wr_data_b  in  DATA_W  write data.
REQ-012 SHALL have ports spr_wr_en  in  1, spr_wr_data  in  DATA_W, spr_rd_data  out  DATA_W  side channel to special register NREG-1.
REQ-013 SHALL have ports rsv_en  in  1, rsv_addr  in  ADDR_W  reservation (mark register pending).
REQ-014 SHALL have ports busy_a, busy_b  out  1  pending flag of register at rd_addr_a / rd_addr_b.

Function
REQ-015 SHALL update registers only on rising clk while rst is high.
REQ-016 SHALL write wr_data_x to register wr_addr_x at the clock edge when wr_en_x is 1.
REQ-017 SHALL, when both ports write the same address in one cycle, store wr_data_b (port B wins).
REQ-018 SHALL write spr_wr_data to register NREG-1 when spr_wr_en is 1 and neither write port targets NREG-1 that cycle; otherwise the write port value wins.
REQ-019 SHALL drive spr_rd_data continuously with register NREG-1 contents (no bypass).
REQ-020 SHALL drive rd_data_x with the stored value of rd_addr_x when no same-cycle write hits that address, or BYPASS is 0.
REQ-021 SHALL, when BYPASS is 1, drive rd_data_x with the data that will be stored at the next edge for rd_addr_x, using priority port B > port A > spr channel.
REQ-022 SHALL, when ZERO_REG0 is 1, drive 0 on any read of address 0, including bypass cases.
REQ-023 SHALL keep one pending bit per register; rsv_en sets pending[rsv_addr] at the edge.
REQ-024 SHALL clear pending[n] at the edge where a write port or the spr channel writes register n.
REQ-025 SHALL, when reservation and write hit the same register in one cycle, leave pending set (reservation wins).
REQ-026 SHALL drive busy_x = pending[rd_addr_x] from registered state only (no same-cycle clear forwarding).
REQ-027 SHALL never set pending[0] when ZERO_REG0 is 1; busy reads for address 0 then return 0.
REQ-028 SHALL have no internal latency beyond one edge: writes visible on non-bypass reads the cycle after the write edge.

Reset
REQ-029 SHALL, while rst is 0, asynchronously clear all registers and pending bits to 0, regardless of clk.
REQ-030 SHALL, with rst 0, drive rd_data_a, rd_data_b, spr_rd_data = 0 and busy_a, busy_b = 0 (bypass suppressed during reset).
REQ-031 SHALL ignore writes and reservations presented in the cycle rst deasserts if the edge coincides with deassertion.

Verification
REQ-032 SHALL cover: reset, then wr_en_a=1 addr 1 data 16'hABCD; next cycle rd_addr_a=1 -> rd_data_a=16'hABCD, spr_rd_data=0.
REQ-033 SHALL cover: wr_en_a addr 7 16'h1111 and wr_en_b addr 7 16'h2222 same cycle, BYPASS=1, rd_addr_b=7 -> rd_data_b=16'h2222 that cycle and after.
REQ-034 SHALL cover: spr_wr_en=1 data 16'hAAAA with wr_en_a addr 15 data 16'hBBBB -> spr_rd_data=16'hBBBB next cycle; later spr_wr_en alone 16'h1234 -> 16'h1234.
REQ-035 SHALL cover: rsv_en addr 3 -> busy for addr 3 = 1 next cycle; wr_en_a addr 3 data 16'h5879 -> busy 0 next cycle; rsv and write addr 3 same cycle -> busy stays 1.
REQ-036 SHALL cover: ZERO_REG0=1, write 16'hFFFF to addr 0 and rsv addr 0 -> rd_data=0, busy=0 every cycle.
REQ-037 SHALL cover: registers loaded with nonzero values and addr 5 pending, rst pulsed low mid-cycle -> all reads, spr_rd_data and busy go 0 immediately, before next clk.

Source files
------------

// File: rtl/register_file_param.sv
// register_file_param
//   Parameterised two-write / two-read register file. It also has a side
//   channel to the top register (NREG-1) and a per-register pending
//   (reservation) scoreboard.
//
// Ports
//   clk                      rising-edge clock for all state
//   rst                      asynchronous active-low reset
//   rd_addr_a/_b             read addresses
//   rd_data_a/_b             combinational read data (optional write bypass)
//   wr_en_a/_b, wr_addr_a/_b, wr_data_a/_b   write ports; port B wins on collision
//   spr_wr_en, spr_wr_data   side-channel write to register NREG-1
//   spr_rd_data              register NREG-1 contents, never bypassed
//   rsv_en, rsv_addr         mark a register pending
//   busy_a/_b                pending flag of the register at rd_addr_a/_b
module register_file_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter bit ZERO_REG0 = 1'b0,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              spr_wr_en,
  input  logic [DATA_W-1:0] spr_wr_data,
  output logic [DATA_W-1:0] spr_rd_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SPR_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  // Later assignments override earlier ones, giving spr < port A < port B.
  // The reservation is applied after the write clears so it wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (spr_wr_en) begin
      regs_d[NREG-1] = spr_wr_data;
      pend_d[NREG-1] = 1'b0;
    end
    if (wr_en_a) begin
      regs_d[wr_addr_a] = wr_data_a;
      pend_d[wr_addr_a] = 1'b0;
    end
    if (wr_en_b) begin
      regs_d[wr_addr_b] = wr_data_b;
      pend_d[wr_addr_b] = 1'b0;
    end
    if (rsv_en) begin
      pend_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG0) begin
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read ports: the bypass mirrors the write priority used in regs_d.
  // Everything is forced to zero while reset is asserted, so live write
  // inputs cannot leak through the bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (BYPASS) begin
        if (wr_en_b && (wr_addr_b == rd_addr[p])) begin
          rd_data[p] = wr_data_b;
        end else if (wr_en_a && (wr_addr_a == rd_addr[p])) begin
          rd_data[p] = wr_data_a;
        end else if (spr_wr_en && (rd_addr[p] == SPR_ADDR)) begin
          rd_data[p] = spr_wr_data;
        end
      end
      if (!rst || (ZERO_REG0 && (rd_addr[p] == '0))) begin
        rd_data[p] = '0;
      end
    end
  end

  assign spr_rd_data = rst ? regs_q[NREG-1] : '0;
  assign busy_a      = rst & pend_q[rd_addr_a];
  assign busy_b      = rst & pend_q[rd_addr_b];

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param. It runs three instances on shared
// stimulus: the defaults, ZERO_REG0=1, and BYPASS=0. Expected values are
// queued when stimulus is driven and then popped and compared.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, rsv_addr;
  logic [15:0] wr_data_a, wr_data_b, spr_wr_data;
  logic        wr_en_a, wr_en_b, spr_wr_en, rsv_en;

  logic [15:0] d_rda, d_rdb, d_spr;
  logic        d_bsa, d_bsb;
  logic [15:0] z_rda, z_rdb, z_spr;
  logic        z_bsa, z_bsb;
  logic [15:0] n_rda, n_rdb, n_spr;
  logic        n_bsa, n_bsb;

  always #5 clk = ~clk;

  register_file_param u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d_rda), .rd_data_b(d_rdb),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .spr_wr_en(spr_wr_en), .spr_wr_data(spr_wr_data), .spr_rd_data(d_spr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(d_bsa), .busy_b(d_bsb)
  );

  register_file_param #(.ZERO_REG0(1'b1)) u_dut_z (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_rda), .rd_data_b(z_rdb),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .spr_wr_en(spr_wr_en), .spr_wr_data(spr_wr_data), .spr_rd_data(z_spr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(z_bsa), .busy_b(z_bsb)
  );

  register_file_param #(.BYPASS(1'b0)) u_dut_n (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(n_rda), .rd_data_b(n_rdb),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .spr_wr_en(spr_wr_en), .spr_wr_data(spr_wr_data), .spr_rd_data(n_spr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(n_bsa), .busy_b(n_bsb)
  );

  // Observation selectors
  localparam int RDA = 0, RDB = 1, SPR = 2, BSA = 3, BSB = 4;
  localparam int ZRDA = 5, ZBSA = 6, ZRDB = 7, NRDA = 8, ZSPR = 9;

  int          checks = 0;
  int          errors = 0;
  int          q_sel [$];
  logic [15:0] q_exp [$];
  string       q_tag [$];

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      RDA:     return d_rda;
      RDB:     return d_rdb;
      SPR:     return d_spr;
      BSA:     return {15'd0, d_bsa};
      BSB:     return {15'd0, d_bsb};
      ZRDA:    return z_rda;
      ZBSA:    return {15'd0, z_bsa};
      ZRDB:    return z_rdb;
      NRDA:    return n_rda;
      ZSPR:    return z_spr;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [15:0] exp, input string tag);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic check_all();
    int          sel;
    logic [15:0] exp;
    logic [15:0] obs;
    string       tag;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      exp = q_exp.pop_front();
      tag = q_tag.pop_front();
      obs = observe(sel);
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_a = 1'b0; wr_en_b = 1'b0; spr_wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd_addr_a = 4'd1; rd_addr_b = 4'd0;
    wr_en_a = 1'b1; wr_addr_a = 4'd1; wr_data_a = 16'hDEAD;
    wr_en_b = 1'b0; wr_addr_b = 4'd0; wr_data_b = 16'h0000;
    spr_wr_en = 1'b1; spr_wr_data = 16'hBEEF;
    rsv_en = 1'b1; rsv_addr = 4'd1;

    // Reset with live writes: everything reads zero, bypass suppressed
    #2;
    expect_val(RDA, 16'h0000, "rst_rd_a");
    expect_val(SPR, 16'h0000, "rst_spr");
    expect_val(BSA, 16'h0000, "rst_busy_a");
    check_all();
    repeat (2) @(posedge clk);
    #1;
    expect_val(RDA, 16'h0000, "rst_hold_rd_a");
    check_all();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    expect_val(RDA, 16'h0000, "post_rst_rd_a");
    expect_val(BSA, 16'h0000, "post_rst_busy_a");
    expect_val(SPR, 16'h0000, "post_rst_spr");
    check_all();

    // Basic write and read back; same-cycle bypass vs no-bypass
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd1; wr_data_a = 16'hABCD; rd_addr_a = 4'd1;
    @(negedge clk);
    expect_val(RDA,  16'hABCD, "bypass_a");
    expect_val(NRDA, 16'h0000, "nobypass_a_old");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(RDA,  16'hABCD, "wr_a_readback");
    expect_val(NRDA, 16'hABCD, "nobypass_a_readback");
    expect_val(SPR,  16'h0000, "spr_untouched");
    check_all();

    // Port collision on address 7: port B wins
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 16'h1111;
    wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 16'h2222;
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    @(negedge clk);
    expect_val(RDB,  16'h2222, "collide_bypass_b");
    expect_val(RDA,  16'h2222, "collide_bypass_a");
    expect_val(NRDA, 16'h0000, "collide_nobypass_old");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(RDB,  16'h2222, "collide_stored_b");
    expect_val(NRDA, 16'h2222, "collide_stored_nb");
    check_all();

    // Special register: write port beats spr channel, then spr alone
    tick();
    spr_wr_en = 1'b1; spr_wr_data = 16'hAAAA;
    wr_en_a = 1'b1; wr_addr_a = 4'd15; wr_data_a = 16'hBBBB;
    rd_addr_a = 4'd15;
    @(negedge clk);
    expect_val(RDA, 16'hBBBB, "spr_collide_bypass");
    expect_val(SPR, 16'h0000, "spr_no_bypass");
    check_all();
    tick();
    idle_inputs();
    spr_wr_en = 1'b1; spr_wr_data = 16'h1234;
    @(negedge clk);
    expect_val(SPR, 16'hBBBB, "spr_port_wins");
    expect_val(RDA, 16'h1234, "spr_chan_bypass");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(SPR, 16'h1234, "spr_chan_write");
    expect_val(RDA, 16'h1234, "spr_chan_readback");
    check_all();

    // Reservations on address 3
    tick();
    rsv_en = 1'b1; rsv_addr = 4'd3; rd_addr_a = 4'd3;
    @(negedge clk);
    expect_val(BSA, 16'h0000, "rsv_not_forwarded");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(BSA, 16'h0001, "rsv_set");
    check_all();
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 16'h5879;
    @(negedge clk);
    expect_val(BSA, 16'h0001, "clear_not_forwarded");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(BSA, 16'h0000, "write_clears_rsv");
    expect_val(RDA, 16'h5879, "write_data_3");
    check_all();
    tick();
    rsv_en = 1'b1; rsv_addr = 4'd3;
    wr_en_b = 1'b1; wr_addr_b = 4'd3; wr_data_b = 16'h5A5A;
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(BSA, 16'h0001, "rsv_beats_write");
    expect_val(RDA, 16'h5A5A, "rsv_write_data");
    check_all();

    // Two independent writes in one cycle
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd2; wr_data_a = 16'h0202;
    wr_en_b = 1'b1; wr_addr_b = 4'd4; wr_data_b = 16'h0404;
    tick();
    idle_inputs();
    rd_addr_a = 4'd2; rd_addr_b = 4'd4;
    @(negedge clk);
    expect_val(RDA, 16'h0202, "dual_write_a");
    expect_val(RDB, 16'h0404, "dual_write_b");
    check_all();

    // Register 0: normal on the default instance, hardwired zero on ZERO_REG0
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    @(negedge clk);
    expect_val(RDA,  16'hFFFF, "r0_bypass_default");
    expect_val(ZRDA, 16'h0000, "r0_bypass_zero");
    expect_val(ZBSA, 16'h0000, "r0_busy_zero_same");
    check_all();
    tick();
    idle_inputs();
    @(negedge clk);
    expect_val(RDA,  16'hFFFF, "r0_stored_default");
    expect_val(BSA,  16'h0001, "r0_busy_default");
    expect_val(ZRDA, 16'h0000, "r0_stored_zero");
    expect_val(ZRDB, 16'h0000, "r0_stored_zero_b");
    expect_val(ZBSA, 16'h0000, "r0_busy_zero");
    check_all();

    // Loaded state plus pending addr 5, then a mid-cycle asynchronous reset
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 16'h5555;
    rsv_en = 1'b1; rsv_addr = 4'd5;
    tick();
    idle_inputs();
    rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    @(negedge clk);
    expect_val(RDA,  16'h5555, "pre_rst_rd_a");
    expect_val(RDB,  16'h5555, "pre_rst_rd_b");
    expect_val(BSB,  16'h0001, "pre_rst_busy_b");
    expect_val(SPR,  16'h1234, "pre_rst_spr");
    expect_val(ZSPR, 16'h1234, "pre_rst_spr_z");
    check_all();
    #1;
    wr_en_b = 1'b1; wr_addr_b = 4'd5; wr_data_b = 16'h7777;
    rst = 1'b0;
    #1;
    expect_val(RDA, 16'h0000, "async_rst_rd_a");
    expect_val(RDB, 16'h0000, "async_rst_rd_b");
    expect_val(SPR, 16'h0000, "async_rst_spr");
    expect_val(BSA, 16'h0000, "async_rst_busy_a");
    expect_val(BSB, 16'h0000, "async_rst_busy_b");
    check_all();
    tick();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    expect_val(RDA, 16'h0000, "after_rst_rd_a");
    expect_val(BSA, 16'h0000, "after_rst_busy_a");
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
